// File: rtl/tdm_mux_scanner_pkg.sv
//------------------------------------------------------------------------------
// tdm_mux_scanner_pkg
// State type and helpers for the TDM mux scanner.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none
package tdm_mux_scanner_pkg;

  `include "mux_defs.vh"

  typedef enum logic [1:0] {
    ST_IDLE   = IDLE,
    ST_MANUAL = MANUAL,
    ST_SCAN   = SCAN
  } state_t;

  // Width of a counter that must reach n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mux_defs.vh
//------------------------------------------------------------------------------
// mux_defs.vh
// State encodings shared by the TDM mux scanner.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none
`ifndef MUX_DEFS_VH
`define MUX_DEFS_VH

localparam logic [1:0] IDLE   = 2'd0;
localparam logic [1:0] MANUAL = 2'd1;
localparam logic [1:0] SCAN   = 2'd2;

`endif
`default_nettype wire

// File: rtl/mux_n1.sv
//------------------------------------------------------------------------------
// mux_n1
// Combinational N:1 selector built as a log2 tree of 2:1 stages.
// Leaves beyond N are tied to zero, so an out-of-range select yields 0.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none
module mux_n1 #(
  parameter int WIDTH = 4,
  parameter int N     = 4
) (
  input  logic [N*WIDTH-1:0]   din,
  input  logic [$clog2(N)-1:0] sel,
  output logic [WIDTH-1:0]     y
);

  localparam int SELW = $clog2(N);
  localparam int P    = 1 << SELW;

  logic [WIDTH-1:0] leaf [P];

  // Leaves: real channels first, zero padding up to the next power of two.
  for (genvar k = 0; k < P; k++) begin : g_leaf
    if (k < N) begin : g_used
      assign leaf[k] = din[k*WIDTH +: WIDTH];
    end else begin : g_pad
      assign leaf[k] = '0;
    end
  end

  // Level l pairs adjacent entries of the level below using select bit l.
  for (genvar l = 0; l < SELW; l++) begin : g_lvl
    logic [WIDTH-1:0] stage [P >> (l + 1)];
    for (genvar j = 0; j < (P >> (l + 1)); j++) begin : g_node
      if (l == 0) begin : g_first
        assign stage[j] = sel[l] ? leaf[2*j+1] : leaf[2*j];
      end else begin : g_next
        assign stage[j] = sel[l] ? g_lvl[l-1].stage[2*j+1] : g_lvl[l-1].stage[2*j];
      end
    end
  end

  assign y = g_lvl[SELW-1].stage[0];

endmodule
`default_nettype wire

// File: rtl/tdm_mux_scanner.sv
//------------------------------------------------------------------------------
// tdm_mux_scanner
// Registered N:1 time-division multiplexer with manual select and auto-scan
// with programmable dwell, plus valid and frame-start flags.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none
module tdm_mux_scanner
  import tdm_mux_scanner_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int N     = 4,
  parameter int DWELL = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 mode,
  input  logic [$clog2(N)-1:0] sel_in,
  input  logic [N*WIDTH-1:0]   din,
  output logic [WIDTH-1:0]     dout,
  output logic [$clog2(N)-1:0] ch,
  output logic                 valid,
  output logic                 frame_start
);

  localparam int SELW = $clog2(N);
  localparam int DWW  = cnt_width(DWELL);

  state_t           state, state_nxt;
  logic [SELW-1:0]  ch_cnt, ch_cnt_nxt;
  logic [DWW-1:0]   dwell_cnt, dwell_cnt_nxt;
  logic [SELW-1:0]  scan_ch;
  logic [DWW-1:0]   scan_dwell;
  logic [SELW-1:0]  mux_sel;
  logic [WIDTH-1:0] mux_y;
  logic [WIDTH-1:0] dout_nxt;
  logic [SELW-1:0]  ch_nxt;
  logic             valid_nxt;
  logic             fs_nxt;

  // A scan entered from any other state always starts from channel 0.
  assign scan_ch    = (state == ST_SCAN) ? ch_cnt    : '0;
  assign scan_dwell = (state == ST_SCAN) ? dwell_cnt : '0;
  assign mux_sel    = (en && mode) ? scan_ch : sel_in;

  mux_n1 #(
    .WIDTH (WIDTH),
    .N     (N)
  ) u_mux (
    .din (din),
    .sel (mux_sel),
    .y   (mux_y)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next state, counter advance and next output values.
  always_comb begin
    state_nxt     = ST_IDLE;
    ch_cnt_nxt    = '0;
    dwell_cnt_nxt = '0;
    dout_nxt      = dout;
    ch_nxt        = ch;
    valid_nxt     = 1'b0;
    fs_nxt        = 1'b0;

    if (en) state_nxt = mode ? ST_SCAN : ST_MANUAL;

    case (state_nxt)
      ST_MANUAL: begin
        if (int'(sel_in) < N) begin
          dout_nxt  = mux_y;
          ch_nxt    = sel_in;
          valid_nxt = 1'b1;
        end
      end
      ST_SCAN: begin
        dout_nxt  = mux_y;
        ch_nxt    = scan_ch;
        valid_nxt = 1'b1;
        fs_nxt    = (scan_ch == '0) && (scan_dwell == '0);
        if (scan_dwell == DWW'(DWELL - 1)) begin
          dwell_cnt_nxt = '0;
          ch_cnt_nxt    = (scan_ch == SELW'(N - 1)) ? '0 : scan_ch + 1'b1;
        end else begin
          dwell_cnt_nxt = scan_dwell + 1'b1;
          ch_cnt_nxt    = scan_ch;
        end
      end
      default: ;
    endcase
  end

  // Output and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout        <= '0;
      ch          <= '0;
      valid       <= 1'b0;
      frame_start <= 1'b0;
      ch_cnt      <= '0;
      dwell_cnt   <= '0;
    end else begin
      dout        <= dout_nxt;
      ch          <= ch_nxt;
      valid       <= valid_nxt;
      frame_start <= fs_nxt;
      ch_cnt      <= ch_cnt_nxt;
      dwell_cnt   <= dwell_cnt_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tdm_mux_scanner.sv
//------------------------------------------------------------------------------
// tb_tdm_mux_scanner
// Directed bench for the TDM mux scanner: a 4-channel/dwell-1 instance and a
// 3-channel/dwell-3 instance.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none
module tb_tdm_mux_scanner;

  logic clk;
  logic rst;

  logic        en4, mode4;
  logic [1:0]  sel4;
  logic [15:0] din4;
  logic [3:0]  dout4;
  logic [1:0]  ch4;
  logic        valid4, fs4;

  logic        en3, mode3;
  logic [1:0]  sel3;
  logic [11:0] din3;
  logic [3:0]  dout3;
  logic [1:0]  ch3;
  logic        valid3, fs3;

  int errors = 0;
  int checks = 0;

  tdm_mux_scanner #(.WIDTH(4), .N(4), .DWELL(1)) dut4 (
    .clk (clk), .rst (rst), .en (en4), .mode (mode4), .sel_in (sel4),
    .din (din4), .dout (dout4), .ch (ch4), .valid (valid4), .frame_start (fs4)
  );

  tdm_mux_scanner #(.WIDTH(4), .N(3), .DWELL(3)) dut3 (
    .clk (clk), .rst (rst), .en (en3), .mode (mode3), .sel_in (sel3),
    .din (din3), .dout (dout3), .ch (ch3), .valid (valid3), .frame_start (fs3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check4(input string tag, input logic [3:0] d, input logic [1:0] c,
                        input logic v, input logic f);
    check({tag, ".dout"},  32'(dout4),  32'(d));
    check({tag, ".ch"},    32'(ch4),    32'(c));
    check({tag, ".valid"}, 32'(valid4), 32'(v));
    check({tag, ".fs"},    32'(fs4),    32'(f));
  endtask

  task automatic check3(input string tag, input logic [3:0] d, input logic [1:0] c,
                        input logic v, input logic f);
    check({tag, ".dout"},  32'(dout3),  32'(d));
    check({tag, ".ch"},    32'(ch3),    32'(c));
    check({tag, ".valid"}, 32'(valid3), 32'(v));
    check({tag, ".fs"},    32'(fs3),    32'(f));
  endtask

  logic [3:0] exp_d4 [5];
  logic [1:0] exp_c4 [5];
  logic       exp_f4 [5];
  logic [3:0] chan3  [3];

  initial begin
    exp_d4 = '{4'b0001, 4'b0010, 4'b0100, 4'b1100, 4'b0001};
    exp_c4 = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    exp_f4 = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    chan3  = '{4'hA, 4'hB, 4'hC};

    rst  = 1'b1;
    en4  = 1'b0; mode4 = 1'b0; sel4 = 2'd0;
    din4 = {4'b1100, 4'b0100, 4'b0010, 4'b0001};
    en3  = 1'b0; mode3 = 1'b0; sel3 = 2'd0;
    din3 = {4'hC, 4'hB, 4'hA};

    // Reset state.
    step();
    step();
    check4("reset4", 4'd0, 2'd0, 1'b0, 1'b0);
    check3("reset3", 4'd0, 2'd0, 1'b0, 1'b0);
    rst = 1'b0;
    step();
    check4("idle4", 4'd0, 2'd0, 1'b0, 1'b0);

    // Manual select.
    en4 = 1'b1; mode4 = 1'b0; sel4 = 2'd2;
    step();
    check4("man_sel2", 4'b0100, 2'd2, 1'b1, 1'b0);
    sel4 = 2'd3;
    step();
    check4("man_sel3", 4'b1100, 2'd3, 1'b1, 1'b0);

    // Scan, dwell 1: 0,1,2,3,0.
    mode4 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check4($sformatf("scan4_%0d", i), exp_d4[i], exp_c4[i], 1'b1, exp_f4[i]);
    end
    step();
    check4("scan4_5", 4'b0010, 2'd1, 1'b1, 1'b0);
    step();
    check4("scan4_6", 4'b0100, 2'd2, 1'b1, 1'b0);

    // Mode switch mid-frame, then scan restarts at channel 0.
    mode4 = 1'b0; sel4 = 2'd1;
    step();
    check4("switch_man", 4'b0010, 2'd1, 1'b1, 1'b0);
    mode4 = 1'b1;
    step();
    check4("switch_scan", 4'b0001, 2'd0, 1'b1, 1'b1);
    step();
    check4("switch_scan1", 4'b0010, 2'd1, 1'b1, 1'b0);

    // Asynchronous reset mid-scan.
    rst = 1'b1;
    #1;
    check4("async_rst", 4'd0, 2'd0, 1'b0, 1'b0);
    en4 = 1'b0;
    step();
    rst = 1'b0;
    step();
    check4("post_rst0", 4'd0, 2'd0, 1'b0, 1'b0);
    step();
    check4("post_rst1", 4'd0, 2'd0, 1'b0, 1'b0);

    // Scan, N=3, dwell 3: each channel held 3 cycles, frame of 9.
    en3 = 1'b1; mode3 = 1'b1;
    for (int i = 0; i < 19; i++) begin
      step();
      check3($sformatf("scan3_%0d", i), chan3[(i / 3) % 3], 2'((i / 3) % 3), 1'b1,
             ((i % 9) == 0) ? 1'b1 : 1'b0);
    end

    // Out-of-range select holds, then disable holds.
    mode3 = 1'b0; sel3 = 2'd1;
    step();
    check3("man3_sel1", 4'hB, 2'd1, 1'b1, 1'b0);
    sel3 = 2'd3;
    step();
    check3("man3_oor", 4'hB, 2'd1, 1'b0, 1'b0);
    sel3 = 2'd2;
    step();
    check3("man3_sel2", 4'hC, 2'd2, 1'b1, 1'b0);
    en3 = 1'b0;
    step();
    check3("idle3", 4'hC, 2'd2, 1'b0, 1'b0);
    din3 = {4'h1, 4'h2, 4'h3};
    step();
    check3("idle3_hold", 4'hC, 2'd2, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
